mux_bit_sequencer: RTL and testbench

- Upstream driver for the 8:1 bit-select mux stage. Accepts one byte per valid/ready handshake and holds it on data_out, which feeds the mux data inputs.
- Steps sel through all 8 indices, holding each index DIV cycles, so the mux output produces a timed serial bitstream.
- Generates bit/frame strobes for downstream capture and inserts a programmable idle gap between frames.

---
 rtl/mux_bit_sequencer_pkg.sv | 16 +
 rtl/mux_bit_sequencer_if.sv | 24 ++
 rtl/mux_bit_sequencer_mod_n_counter.sv | 35 +++
 rtl/mux_bit_sequencer.sv | 132 +++++++++++++
 tb/tb_mux_bit_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_bit_sequencer_pkg.sv
// Shared definitions for the mux bit sequencer: FSM state encoding and
// the counter width helper used to size the cycle counters.
package mux_bit_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  // A counter that counts 0..n-1 never needs fewer than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_bit_sequencer_if.sv
// Byte handshake plus the serialiser outputs that feed the 8:1 mux stage.
interface mux_bit_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic [2:0] sel;
  logic       busy;
  logic       bit_stb;
  logic       last;
  logic       done;

  modport master (
    output in_data, in_valid,
    input  in_ready, data_out, sel, busy, bit_stb, last, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data_out, sel, busy, bit_stb, last, done
  );

endinterface

// File: rtl/mux_bit_sequencer_mod_n_counter.sv
// Modulo-N counter with synchronous clear and a terminal-count flag; it wraps
// to zero when enabled on its terminal value.
module mod_n_counter
  import mux_bit_sequencer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  // N=0 builds a counter that sits at zero.
  localparam logic [W-1:0] LAST = (N > 0) ? W'(N - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/mux_bit_sequencer.sv
// Captures one byte per handshake and walks the mux select through all eight
// bit positions, DIV cycles each, with bit/frame strobes and an idle gap.
module mux_bit_sequencer
  import mux_bit_sequencer_pkg::*;
#(
  parameter int DIV     = 4,
  parameter int GAP     = 1,
  parameter bit DESCEND = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_bit_sequencer_if.slave bus
);

  localparam int             DW        = cnt_width(DIV);
  localparam int             GW        = cnt_width(GAP);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
  localparam logic [2:0]     SEL_FIRST = DESCEND ? 3'd7 : 3'd0;

  state_t        r_state;
  state_t        w_state_next;

  logic [7:0]    r_data_out;
  logic [2:0]    r_sel;
  logic [2:0]    r_bit_cnt;
  logic          r_busy;
  logic          r_bit_stb;
  logic          r_last;
  logic          r_done;

  logic [DW-1:0] w_div_cnt;
  logic [DW-1:0] w_div_next;
  logic          w_div_tc;
  logic [GW-1:0] w_gap_cnt;
  logic          w_gap_tc;
  logic          w_unused_gap;

  logic          w_accept;
  logic          w_step;
  logic          w_frame_end;
  logic [2:0]    w_bit_next;
  logic          w_done_next;

  assign w_accept    = (r_state == IDLE) && bus.in_valid;
  assign w_step      = (r_state == SHIFT) && w_div_tc && (r_bit_cnt != 3'd7);
  assign w_frame_end = (r_state == SHIFT) && w_div_tc && (r_bit_cnt == 3'd7);
  assign w_bit_next  = w_step ? r_bit_cnt + 3'd1 : r_bit_cnt;
  assign w_div_next  = w_div_tc ? '0 : w_div_cnt + 1'b1;

  // done is registered, so it is raised on the edge entering the frame's final cycle.
  assign w_done_next = (r_state == SHIFT) && !w_frame_end &&
                       (w_bit_next == 3'd7) && (w_div_next == DIV_LAST);

  mod_n_counter #(.N(DIV), .W(DW)) u_div_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == SHIFT),
    .i_clr (w_accept),
    .o_cnt (w_div_cnt),
    .o_tc  (w_div_tc)
  );

  mod_n_counter #(.N(GAP), .W(GW)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == GAPW),
    .i_clr (w_frame_end),
    .o_cnt (w_gap_cnt),
    .o_tc  (w_gap_tc)
  );

  // Only the terminal flag of the gap counter steers the FSM.
  assign w_unused_gap = ^w_gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_next = SHIFT;
      SHIFT:   if (w_frame_end) w_state_next = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (w_gap_tc) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_sel      <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_bit_stb  <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_bit_stb <= 1'b0;
      r_done    <= w_done_next;
      if (w_accept) begin
        r_data_out <= bus.in_data;
        r_sel      <= SEL_FIRST;
        r_bit_cnt  <= 3'd0;
        r_busy     <= 1'b1;
        r_bit_stb  <= 1'b1;
        r_last     <= 1'b0;
      end else if (w_step) begin
        r_bit_cnt <= w_bit_next;
        r_sel     <= DESCEND ? r_sel - 3'd1 : r_sel + 3'd1;
        r_bit_stb <= 1'b1;
        r_last    <= (w_bit_next == 3'd7);
      end else if (w_frame_end) begin
        r_busy <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.data_out = r_data_out;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.bit_stb  = r_bit_stb;
  assign bus.last     = r_last;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_mux_bit_sequencer.sv
// Exercises three sequencer configurations against a cycle-indexed frame
// model, a behavioural 8:1 mux and a byte scoreboard.
module tb_mux_bit_sequencer;

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic [2:0] sel;
    logic       stb;
    logic       last;
    logic       done;
    logic [7:0] data;
  } view_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tbData = 8'h00;
  logic       tbValid = 1'b0;
  int         dutSel = 0;
  int         nChecks = 0;
  int         nFails = 0;
  view_t      obs;
  logic       muxOut;

  always #5 clk = ~clk;

  mux_bit_sequencer_if ifA ();
  mux_bit_sequencer_if ifB ();
  mux_bit_sequencer_if ifC ();

  assign ifA.in_data  = tbData;
  assign ifB.in_data  = tbData;
  assign ifC.in_data  = tbData;
  assign ifA.in_valid = tbValid && (dutSel == 0);
  assign ifB.in_valid = tbValid && (dutSel == 1);
  assign ifC.in_valid = tbValid && (dutSel == 2);

  mux_bit_sequencer #(.DIV(2), .GAP(1), .DESCEND(1'b0)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  mux_bit_sequencer #(.DIV(1), .GAP(0), .DESCEND(1'b1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  mux_bit_sequencer #(.DIV(3), .GAP(2), .DESCEND(1'b0)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  always_comb begin
    case (dutSel)
      1:       obs = {ifB.busy, ifB.in_ready, ifB.sel, ifB.bit_stb, ifB.last, ifB.done, ifB.data_out};
      2:       obs = {ifC.busy, ifC.in_ready, ifC.sel, ifC.bit_stb, ifC.last, ifC.done, ifC.data_out};
      default: obs = {ifA.busy, ifA.in_ready, ifA.sel, ifA.bit_stb, ifA.last, ifA.done, ifA.data_out};
    endcase
  end

  // The downstream 8:1 mux stage the sequencer drives.
  assign muxOut = obs.data[obs.sel];

  // Expected outputs k cycles after the accepting edge, straight from the frame timeline.
  function automatic view_t model(input int k, input int div, input int gap, input bit desc,
                                  input logic [7:0] b);
    view_t e;
    int    n;
    int    idx;
    e      = '0;
    e.data = b;
    n      = 8 * div;
    if (k <= n) begin
      idx    = (k - 1) / div;
      e.busy = 1'b1;
      e.sel  = desc ? 3'(7 - idx) : 3'(idx);
      e.stb  = ((k - 1) % div) == 0;
      e.last = (idx == 7);
      e.done = (k == n);
    end else begin
      e.rdy = (k > n + gap);
      e.sel = desc ? 3'd0 : 3'd7;
    end
    return e;
  endfunction

  function automatic view_t resetView();
    view_t v;
    v     = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  // Presents a byte, waits (bounded) for in_ready, and returns one cycle after the accept.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited  = 0;
    tbData  = b;
    tbValid = 1'b1;
    while (obs.rdy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    nChecks++;
    if (obs.rdy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL accept_timeout dut=%0d in_ready=%b want 1", dutSel, obs.rdy);
    end
    @(posedge clk);
    @(negedge clk);
    tbValid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dutSel = d;
      #1;
      nChecks++;
      if (obs !== resetView()) begin
        nFails++;
        $display("[TB] FAIL reset_held dut=%0d got %h want %h", d, obs, resetView());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      dutSel = d;
      #1;
      nChecks++;
      if (obs !== resetView()) begin
        nFails++;
        $display("[TB] FAIL reset_released dut=%0d got %h want %h", d, obs, resetView());
      end
    end
    dutSel = 0;
  endtask

  task automatic test_frame_ascending();
    view_t e;
    int    stbCount;
    int    doneK;
    int    rdyK;
    stbCount = 0;
    doneK    = 0;
    rdyK     = 0;
    dutSel   = 0;
    @(negedge clk);
    applyStimulus(8'hB2);
    for (int k = 1; k <= 20; k++) begin
      e = model(k, 2, 1, 1'b0, 8'hB2);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL asc_frame k=%0d got %h want %h", k, obs, e);
      end
      if (obs.stb === 1'b1) stbCount++;
      if (obs.done === 1'b1) doneK = k;
      if (obs.rdy === 1'b1 && rdyK == 0) rdyK = k;
      @(negedge clk);
    end
    nChecks++;
    if (stbCount != 8) begin
      nFails++;
      $display("[TB] FAIL asc_stb_count got %0d want 8", stbCount);
    end
    nChecks++;
    if (doneK != 16) begin
      nFails++;
      $display("[TB] FAIL asc_done_cycle got %0d want 16", doneK);
    end
    nChecks++;
    if (rdyK != 18) begin
      nFails++;
      $display("[TB] FAIL asc_ready_cycle got %0d want 18", rdyK);
    end
  endtask

  task automatic test_descending_back_to_back();
    view_t e;
    dutSel = 1;
    @(negedge clk);
    applyStimulus(8'h5A);
    for (int k = 1; k <= 9; k++) begin
      e = model(k, 1, 0, 1'b1, 8'h5A);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL desc_frame k=%0d got %h want %h", k, obs, e);
      end
      if (k < 9) @(negedge clk);
    end
    applyStimulus(8'hA5);
    for (int k = 1; k <= 10; k++) begin
      e = model(k, 1, 0, 1'b1, 8'hA5);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL desc_b2b k=%0d got %h want %h", k, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_held_valid();
    view_t e;
    dutSel = 0;
    @(negedge clk);
    tbData  = 8'h01;
    tbValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tbData = 8'h02;
    for (int k = 1; k <= 30; k++) begin
      e = (k <= 18) ? model(k, 2, 1, 1'b0, 8'h01) : model(k - 18, 2, 1, 1'b0, 8'h02);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL held_valid k=%0d got %h want %h", k, obs, e);
      end
      @(negedge clk);
    end
    tbValid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    view_t e;
    dutSel = 0;
    @(negedge clk);
    applyStimulus(8'hE7);
    for (int k = 1; k <= 4; k++) begin
      e = model(k, 2, 1, 1'b0, 8'hE7);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL pre_reset k=%0d got %h want %h", k, obs, e);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (obs !== resetView()) begin
      nFails++;
      $display("[TB] FAIL async_reset got %h want %h", obs, resetView());
    end
    tbData  = 8'hFF;
    tbValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nChecks++;
      if (obs !== resetView()) begin
        nFails++;
        $display("[TB] FAIL in_reset c=%0d got %h want %h", c, obs, resetView());
      end
    end
    tbValid = 1'b0;
    rst_n   = 1'b1;
    applyStimulus(8'h3C);
    for (int k = 1; k <= 20; k++) begin
      e = model(k, 2, 1, 1'b0, 8'h3C);
      nChecks++;
      if (obs !== e) begin
        nFails++;
        $display("[TB] FAIL post_reset k=%0d got %h want %h", k, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mux_scoreboard();
    view_t      e;
    logic [7:0] b;
    logic [7:0] recon;
    dutSel = 2;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      b     = 8'($urandom);
      recon = 8'h00;
      applyStimulus(b);
      for (int k = 1; k <= 27; k++) begin
        e = model(k, 3, 2, 1'b0, b);
        nChecks++;
        if (obs !== e) begin
          nFails++;
          $display("[TB] FAIL mux_frame t=%0d k=%0d got %h want %h", t, k, obs, e);
        end
        if (obs.busy === 1'b1) begin
          nChecks++;
          if (muxOut !== b[e.sel]) begin
            nFails++;
            $display("[TB] FAIL mux_bit t=%0d k=%0d got %b want %b", t, k, muxOut, b[e.sel]);
          end
          if (obs.stb === 1'b1) recon[obs.sel] = muxOut;
        end
        @(negedge clk);
      end
      nChecks++;
      if (recon !== b) begin
        nFails++;
        $display("[TB] FAIL mux_recon t=%0d got %h want %h", t, recon, b);
      end
    end
  endtask

  task automatic test_stress();
    logic [7:0] q[$];
    logic [7:0] recon;
    int         sent;
    int         accepts;
    int         dones;
    int         kS;
    int         cycles;
    bit         pending;
    bit         expRdy;
    bit         expBusy;
    sent    = 0;
    accepts = 0;
    dones   = 0;
    kS      = -1;
    cycles  = 0;
    pending = 1'b0;
    recon   = 8'h00;
    dutSel  = 1;
    @(negedge clk);
    while (dones < 100 && cycles < 5000) begin
      expRdy  = (kS < 0) || (kS > 8);
      expBusy = (kS >= 1) && (kS <= 8);
      nChecks++;
      if (obs.rdy !== expRdy || obs.busy !== expBusy || obs.done !== (kS == 8)) begin
        nFails++;
        $display("[TB] FAIL stress_ctrl cyc=%0d got rdy/busy/done %b%b%b want %b%b%b",
                 cycles, obs.rdy, obs.busy, obs.done, expRdy, expBusy, kS == 8);
      end
      if (obs.stb === 1'b1) recon[obs.sel] = muxOut;
      if (obs.done === 1'b1) begin
        nChecks++;
        if (q.size() == 0 || recon !== q[0]) begin
          nFails++;
          $display("[TB] FAIL stress_byte done=%0d got %h want %h", dones, recon,
                   (q.size() == 0) ? 8'hxx : q[0]);
        end
        if (q.size() > 0) void'(q.pop_front());
        dones++;
      end
      if (!pending && sent < 100) begin
        tbData  = 8'($urandom);
        pending = 1'b1;
        sent++;
      end
      tbValid = pending && ($urandom_range(0, 3) != 0);
      if (tbValid && expRdy) begin
        q.push_back(tbData);
        accepts++;
        pending = 1'b0;
        kS      = 0;
      end
      @(negedge clk);
      cycles++;
      if (kS >= 0) kS++;
    end
    tbValid = 1'b0;
    nChecks++;
    if (accepts != 100) begin
      nFails++;
      $display("[TB] FAIL stress_accepts got %0d want 100", accepts);
    end
    nChecks++;
    if (dones != accepts) begin
      nFails++;
      $display("[TB] FAIL stress_dones got %0d want %0d", dones, accepts);
    end
    nChecks++;
    if (q.size() != 0) begin
      nFails++;
      $display("[TB] FAIL stress_leftover got %0d want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_ascending();
    test_descending_back_to_back();
    test_held_valid();
    test_reset_mid_frame();
    test_mux_scoreboard();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
